// File: rtl/m68k_bus_pkg.sv
// Shared definitions for the 68000 bus arbiter: state encodings, default
// parameter values and the per-state output decode.
package m68k_bus_pkg;

  // Default synchronizer depth on M68K_BR_n / M68K_BGACK_n
  localparam int DEF_SYNC_STAGES    = 2;
  // Default c7m falling edges between BGACK_n release and driver re-enable
  localparam int DEF_RECLAIM_CYCLES = 2;
  // Default c7m falling edges allowed in GRANT before giving up
  localparam int DEF_GRANT_TIMEOUT  = 63;

  // Arbiter states (legacy-compatible constant encoding)
  typedef logic [2:0] arb_state_t;
  localparam arb_state_t ST_RESYNC  = 3'd0;
  localparam arb_state_t ST_IDLE    = 3'd1;
  localparam arb_state_t ST_DRAIN   = 3'd2;
  localparam arb_state_t ST_GRANT   = 3'd3;
  localparam arb_state_t ST_MASTER  = 3'd4;
  localparam arb_state_t ST_RECLAIM = 3'd5;

  // Output decode per state: {bg_n, bus_oe, op_hold, ext_master}.
  // Unknown encodings fall back to the safe RESYNC outputs.
  function automatic logic [3:0] state_outputs(input arb_state_t st);
    logic [3:0] o;
    case (st)
      ST_RESYNC:  o = 4'b1010;
      ST_IDLE:    o = 4'b1100;
      ST_DRAIN:   o = 4'b1110;
      ST_GRANT:   o = 4'b0110;
      ST_MASTER:  o = 4'b1011;
      ST_RECLAIM: o = 4'b1010;
      default:    o = 4'b1010;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/m68k_bus_arbiter_sync_ff.sv
// Multi-stage synchronizer that resets to 1 (the negated level of the
// active-low 68000 bus handshake lines).
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain_r;

  // Shift the raw input through STAGES flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_r <= {STAGES{1'b1}};
    end else begin
      chain_r[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        chain_r[i] <= chain_r[i-1];
      end
    end
  end

  assign q = chain_r[STAGES-1];

endmodule

// File: rtl/m68k_bus_arbiter.sv
// Arbitrates the 68000 bus between the PiStorm transaction engine (default
// owner) and an external BR/BG/BGACK bus master. All outputs are registered
// from the next state so there is no input-to-output combinational path.
module m68k_bus_arbiter
  import m68k_bus_pkg::*;
#(
  parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
  parameter int RECLAIM_CYCLES = DEF_RECLAIM_CYCLES,
  parameter int GRANT_TIMEOUT  = DEF_GRANT_TIMEOUT
) (
  input  logic c200m,
  input  logic reset_n,
  input  logic c7m_rising,
  input  logic c7m_falling,
  input  logic arb_en,
  input  logic engine_idle,
  input  logic M68K_BR_n,
  input  logic M68K_BGACK_n,
  output logic M68K_BG_n,
  output logic bus_oe,
  output logic op_hold,
  output logic ext_master,
  output logic grant_timeout
);

  localparam int RS_W = $clog2(SYNC_STAGES + 2);
  localparam int GT_W = $clog2(GRANT_TIMEOUT + 1);
  localparam int RC_W = $clog2(RECLAIM_CYCLES + 1);
  localparam logic [RS_W-1:0] RS_LAST = RS_W'(SYNC_STAGES);
  localparam logic [GT_W-1:0] GT_LAST = GT_W'(GRANT_TIMEOUT - 1);
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(RECLAIM_CYCLES - 1);

  logic       br_s;
  logic       bgack_s;
  arb_state_t state_r;
  arb_state_t state_nxt_s;
  logic       timeout_hit_s;
  logic [RS_W-1:0] rs_cnt_r;
  logic [GT_W-1:0] gt_cnt_r;
  logic [RC_W-1:0] rc_cnt_r;
  logic       bg_n_r;
  logic       bus_oe_r;
  logic       op_hold_r;
  logic       ext_master_r;
  logic       grant_timeout_r;

  // The rising-edge pulse is not needed for arbitration decisions
  logic unused_s;
  assign unused_s = c7m_rising;

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_br (
    .clk   (c200m),
    .rst_n (reset_n),
    .d     (M68K_BR_n),
    .q     (br_s)
  );

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_bgack (
    .clk   (c200m),
    .rst_n (reset_n),
    .d     (M68K_BGACK_n),
    .q     (bgack_s)
  );

  // Next-state logic; an asserted BGACK always takes priority over BR release
  always_comb begin
    state_nxt_s   = state_r;
    timeout_hit_s = 1'b0;
    case (state_r)
      ST_RESYNC: begin
        if (rs_cnt_r == RS_LAST) begin
          state_nxt_s = bgack_s ? ST_IDLE : ST_MASTER;
        end else begin
          state_nxt_s = ST_RESYNC;
        end
      end
      ST_IDLE: begin
        if (!bgack_s) begin
          state_nxt_s = ST_MASTER;
        end else if (!br_s && arb_en) begin
          state_nxt_s = ST_DRAIN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (!bgack_s) begin
          state_nxt_s = ST_MASTER;
        end else if (br_s || !arb_en) begin
          state_nxt_s = ST_IDLE;
        end else if (c7m_falling && engine_idle) begin
          state_nxt_s = ST_GRANT;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      ST_GRANT: begin
        if (!bgack_s) begin
          state_nxt_s = ST_MASTER;
        end else if (br_s) begin
          state_nxt_s = ST_IDLE;
        end else if (c7m_falling && (gt_cnt_r == GT_LAST)) begin
          timeout_hit_s = 1'b1;
          state_nxt_s   = ST_IDLE;
        end else begin
          state_nxt_s = ST_GRANT;
        end
      end
      ST_MASTER: begin
        if (bgack_s) begin
          state_nxt_s = ST_RECLAIM;
        end else begin
          state_nxt_s = ST_MASTER;
        end
      end
      ST_RECLAIM: begin
        if (!bgack_s) begin
          state_nxt_s = ST_MASTER;
        end else if (c7m_falling && (rc_cnt_r == RC_LAST)) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RECLAIM;
        end
      end
      default: begin
        state_nxt_s = ST_RESYNC;
      end
    endcase
  end

  // State register plus per-state counters; each counter is held at zero
  // outside its own state so it starts fresh on every entry
  always_ff @(posedge c200m or negedge reset_n) begin
    if (!reset_n) begin
      state_r  <= ST_RESYNC;
      rs_cnt_r <= {RS_W{1'b0}};
      gt_cnt_r <= {GT_W{1'b0}};
      rc_cnt_r <= {RC_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      if ((state_r == ST_RESYNC) && (rs_cnt_r != RS_LAST)) begin
        rs_cnt_r <= rs_cnt_r + RS_W'(1);
      end
      if (state_r != ST_GRANT) begin
        gt_cnt_r <= {GT_W{1'b0}};
      end else if (c7m_falling) begin
        gt_cnt_r <= gt_cnt_r + GT_W'(1);
      end
      if (state_r != ST_RECLAIM) begin
        rc_cnt_r <= {RC_W{1'b0}};
      end else if (c7m_falling) begin
        rc_cnt_r <= rc_cnt_r + RC_W'(1);
      end
    end
  end

  // Registered outputs decoded from the next state; sticky timeout flag
  // cleared whenever arbitration is disabled
  always_ff @(posedge c200m or negedge reset_n) begin
    if (!reset_n) begin
      bg_n_r          <= 1'b1;
      bus_oe_r        <= 1'b0;
      op_hold_r       <= 1'b1;
      ext_master_r    <= 1'b0;
      grant_timeout_r <= 1'b0;
    end else begin
      {bg_n_r, bus_oe_r, op_hold_r, ext_master_r} <= state_outputs(state_nxt_s);
      if (!arb_en) begin
        grant_timeout_r <= 1'b0;
      end else if (timeout_hit_s) begin
        grant_timeout_r <= 1'b1;
      end
    end
  end

  assign M68K_BG_n     = bg_n_r;
  assign bus_oe        = bus_oe_r;
  assign op_hold       = op_hold_r;
  assign ext_master    = ext_master_r;
  assign grant_timeout = grant_timeout_r;

endmodule

// File: tb/tb_m68k_bus_arbiter.sv
// Directed, table-driven bench for m68k_bus_arbiter. Output vectors are
// {BG_n, bus_oe, op_hold, ext_master, grant_timeout}.
module tb_m68k_bus_arbiter;

  localparam logic [4:0] O_RESYNC  = 5'b10100;
  localparam logic [4:0] O_IDLE    = 5'b11000;
  localparam logic [4:0] O_IDLE_TO = 5'b11001;
  localparam logic [4:0] O_DRAIN   = 5'b11100;
  localparam logic [4:0] O_GRANT   = 5'b01100;
  localparam logic [4:0] O_MASTER  = 5'b10110;
  localparam logic [4:0] O_RECLAIM = 5'b10100;

  typedef struct {
    logic       br_n;
    logic       bgack_n;
    logic       en;
    logic       eidle;
    logic       fall;
    logic [4:0] exp;
    string      name;
  } vec_t;

  logic c200m = 1'b0;
  logic reset_n;
  logic c7m_rising;
  logic c7m_falling;
  logic arb_en;
  logic engine_idle;
  logic br_n;
  logic bgack_n;
  logic bg_n;
  logic bus_oe;
  logic op_hold;
  logic ext_master;
  logic grant_timeout;

  int checks = 0;
  int errors = 0;
  vec_t vecs[$];

  m68k_bus_arbiter dut (
    .c200m         (c200m),
    .reset_n       (reset_n),
    .c7m_rising    (c7m_rising),
    .c7m_falling   (c7m_falling),
    .arb_en        (arb_en),
    .engine_idle   (engine_idle),
    .M68K_BR_n     (br_n),
    .M68K_BGACK_n  (bgack_n),
    .M68K_BG_n     (bg_n),
    .bus_oe        (bus_oe),
    .op_hold       (op_hold),
    .ext_master    (ext_master),
    .grant_timeout (grant_timeout)
  );

  // 200 MHz-style system clock
  always #5 c200m = ~c200m;

  task automatic tick();
    @(posedge c200m);
    #1;
  endtask

  task automatic check(input string name, input logic [4:0] exp);
    logic [4:0] act;
    act = {bg_n, bus_oe, op_hold, ext_master, grant_timeout};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (bg_n,oe,hold,ext,to)", name, act, exp);
    end
  endtask

  task automatic add(input logic b, input logic g, input logic e, input logic i,
                     input logic f, input logic [4:0] exp, input string name);
    vec_t v;
    v.br_n = b; v.bgack_n = g; v.en = e; v.eidle = i; v.fall = f;
    v.exp = exp; v.name = name;
    vecs.push_back(v);
  endtask

  initial begin
    reset_n = 1'b0; c7m_rising = 1'b0; c7m_falling = 1'b0;
    arb_en = 1'b1; engine_idle = 1'b1; br_n = 1'b1; bgack_n = 1'b1;

    // Reset and RESYNC
    tick(); tick();
    check("reset_values", O_RESYNC);
    reset_n = 1'b1;
    tick(); check("resync_1", O_RESYNC);
    tick(); check("resync_2", O_RESYNC);
    tick(); check("resync_idle", O_IDLE);

    // Full grant / master / reclaim handshake, with BR release and BGACK
    // arriving on the same cycle in GRANT (BGACK wins)
    add(1'b0,1'b1,1'b1,1'b1,1'b0, O_IDLE,    "br_sync_1");
    add(1'b0,1'b1,1'b1,1'b1,1'b0, O_IDLE,    "br_sync_2");
    add(1'b0,1'b1,1'b1,1'b1,1'b0, O_DRAIN,   "op_hold_latency");
    add(1'b0,1'b1,1'b1,1'b1,1'b1, O_GRANT,   "bg_on_fall");
    add(1'b1,1'b0,1'b1,1'b1,1'b0, O_GRANT,   "bgack_sync_1");
    add(1'b1,1'b0,1'b1,1'b1,1'b0, O_GRANT,   "bgack_sync_2");
    add(1'b1,1'b0,1'b1,1'b1,1'b0, O_MASTER,  "bgack_wins_tie");
    add(1'b1,1'b1,1'b1,1'b1,1'b0, O_MASTER,  "release_sync_1");
    add(1'b1,1'b1,1'b1,1'b1,1'b0, O_MASTER,  "release_sync_2");
    add(1'b1,1'b1,1'b1,1'b1,1'b0, O_RECLAIM, "reclaim_enter");
    add(1'b1,1'b1,1'b1,1'b1,1'b1, O_RECLAIM, "reclaim_fall_1");
    add(1'b1,1'b1,1'b1,1'b1,1'b0, O_RECLAIM, "reclaim_gap");
    add(1'b1,1'b1,1'b1,1'b1,1'b1, O_IDLE,    "reclaim_done");
    // Engine busy: no grant for 5 c7m cycles, then grant on first fall
    add(1'b0,1'b1,1'b1,1'b0,1'b0, O_IDLE,    "busy_sync_1");
    add(1'b0,1'b1,1'b1,1'b0,1'b0, O_IDLE,    "busy_sync_2");
    add(1'b0,1'b1,1'b1,1'b0,1'b0, O_DRAIN,   "busy_drain");
    for (int k = 0; k < 5; k++) begin
      add(1'b0,1'b1,1'b1,1'b0,1'b1, O_DRAIN, "busy_fall_no_bg");
      add(1'b0,1'b1,1'b1,1'b0,1'b0, O_DRAIN, "busy_gap");
    end
    add(1'b0,1'b1,1'b1,1'b1,1'b0, O_DRAIN,   "idle_wait_fall");
    add(1'b0,1'b1,1'b1,1'b1,1'b1, O_GRANT,   "idle_first_fall");
    // BR withdrawn in GRANT without BGACK
    add(1'b1,1'b1,1'b1,1'b1,1'b0, O_GRANT,   "br_release_1");
    add(1'b1,1'b1,1'b1,1'b1,1'b0, O_GRANT,   "br_release_2");
    add(1'b1,1'b1,1'b1,1'b1,1'b0, O_IDLE,    "br_release_idle");
    // arb_en=0 blocks IDLE->DRAIN and pulls DRAIN back to IDLE
    add(1'b0,1'b1,1'b0,1'b1,1'b0, O_IDLE,    "arb_off_1");
    add(1'b0,1'b1,1'b0,1'b1,1'b0, O_IDLE,    "arb_off_2");
    add(1'b0,1'b1,1'b0,1'b1,1'b0, O_IDLE,    "arb_off_3");
    add(1'b0,1'b1,1'b1,1'b1,1'b0, O_DRAIN,   "arb_on_drain");
    add(1'b0,1'b1,1'b0,1'b1,1'b0, O_IDLE,    "drain_arb_off");
    add(1'b1,1'b1,1'b0,1'b1,1'b0, O_IDLE,    "br_off_1");
    add(1'b1,1'b1,1'b0,1'b1,1'b0, O_IDLE,    "br_off_2");
    add(1'b1,1'b1,1'b1,1'b1,1'b0, O_IDLE,    "arb_back_on");

    for (int i = 0; i < vecs.size(); i++) begin
      br_n = vecs[i].br_n; bgack_n = vecs[i].bgack_n; arb_en = vecs[i].en;
      engine_idle = vecs[i].eidle; c7m_falling = vecs[i].fall;
      tick();
      check(vecs[i].name, vecs[i].exp);
    end
    c7m_falling = 1'b0;

    // Grant timeout after 63 c7m falling edges without BGACK
    br_n = 1'b0;
    tick(); tick(); tick(); check("to_drain", O_DRAIN);
    c7m_falling = 1'b1; tick(); check("to_grant", O_GRANT);
    c7m_falling = 1'b0;
    for (int k = 1; k <= 63; k++) begin
      c7m_falling = 1'b1;
      tick();
      check((k < 63) ? "to_counting" : "to_expired", (k < 63) ? O_GRANT : O_IDLE_TO);
      c7m_falling = 1'b0;
      if (k < 63) begin
        tick();
        check("to_counting_gap", O_GRANT);
      end
    end
    arb_en = 1'b0;
    tick(); check("to_cleared", O_IDLE);
    br_n = 1'b1;
    tick(); tick(); tick(); check("to_quiet", O_IDLE);
    arb_en = 1'b1;

    // BGACK already asserted when reset releases
    reset_n = 1'b0; bgack_n = 1'b0;
    #1 check("rst_bgack_async", O_RESYNC);
    tick(); reset_n = 1'b1;
    tick(); check("rst_bgack_resync_1", O_RESYNC);
    tick(); check("rst_bgack_resync_2", O_RESYNC);
    tick(); check("rst_bgack_master", O_MASTER);
    bgack_n = 1'b1;
    tick(); tick(); check("rst_bgack_still_master", O_MASTER);
    tick(); check("rst_bgack_reclaim", O_RECLAIM);
    c7m_falling = 1'b1; tick(); c7m_falling = 1'b0; tick();
    c7m_falling = 1'b1; tick(); c7m_falling = 1'b0;
    check("rst_bgack_idle", O_IDLE);

    // Reset asserted mid-GRANT while an external master takes the bus
    br_n = 1'b0;
    tick(); tick(); tick(); check("mid_drain", O_DRAIN);
    c7m_falling = 1'b1; tick(); c7m_falling = 1'b0;
    check("mid_grant", O_GRANT);
    reset_n = 1'b0; bgack_n = 1'b0; br_n = 1'b1;
    #1 check("mid_grant_reset_bg", O_RESYNC);
    tick(); reset_n = 1'b1;
    tick(); tick(); check("mid_resync", O_RESYNC);
    tick(); check("mid_master", O_MASTER);
    tick(); check("mid_master_hold", O_MASTER);
    bgack_n = 1'b1;
    tick(); tick(); check("mid_master_release", O_MASTER);
    tick(); check("mid_reclaim", O_RECLAIM);
    c7m_falling = 1'b1; tick(); c7m_falling = 1'b0; tick();
    check("mid_reclaim_hold", O_RECLAIM);
    c7m_falling = 1'b1; tick(); c7m_falling = 1'b0;
    check("mid_idle", O_IDLE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
